// File: rtl/coo_encoder.sv
// Dense-to-COO encoder: takes one adjacency row per handshake and emits one COO write
// per set bit, in row-major, ascending-column order.
module coo_encoder #(
  parameter int MAT_ROWS  = 6,
  parameter int MAT_COLS  = 6,
  parameter int COO_DEPTH = 6,
  parameter int COO_BW    = $clog2(COO_DEPTH),
  parameter int IDX_BW    = $clog2(MAT_ROWS > MAT_COLS ? MAT_ROWS : MAT_COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                row_valid,
  output logic                row_ready,
  input  logic [MAT_COLS-1:0] row_bits,
  output logic                wr_en,
  output logic [COO_BW-1:0]   wr_addr,
  output logic [IDX_BW-1:0]   wr_row,
  output logic [IDX_BW-1:0]   wr_col,
  output logic [COO_BW:0]     nnz_count,
  output logic                overflow,
  output logic                done
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccept = 2'd1;
  localparam logic [1:0] StScan   = 2'd2;
  localparam logic [1:0] StFinish = 2'd3;

  localparam logic [COO_BW:0]   NnzFull = (COO_BW + 1)'(COO_DEPTH);
  localparam logic [IDX_BW-1:0] LastRow = IDX_BW'(MAT_ROWS - 1);

  logic [1:0]          state_q;
  logic [MAT_COLS-1:0] mask_q;
  logic [IDX_BW-1:0]   row_q;
  logic [COO_BW:0]     nnz_q;
  logic                ovf_q;
  logic [COO_BW-1:0]   addr_q;
  logic [IDX_BW-1:0]   wrow_q;
  logic [IDX_BW-1:0]   wcol_q;

  logic                full;
  logic                last_row;
  logic [IDX_BW-1:0]   col_idx;
  logic [MAT_COLS-1:0] mask_clr;

  always_comb begin
    // Descending scan so the lowest set bit is the one left in col_idx.
    col_idx = '0;
    for (int j = MAT_COLS - 1; j >= 0; j--) begin
      if (mask_q[j]) col_idx = IDX_BW'(j);
    end
    mask_clr  = mask_q & (mask_q - 1'b1);
    full      = (nnz_q == NnzFull);
    last_row  = (row_q == LastRow);
    wr_en     = (state_q == StScan) && !full;
    wr_addr   = wr_en ? nnz_q[COO_BW-1:0] : addr_q;
    wr_row    = wr_en ? row_q : wrow_q;
    wr_col    = wr_en ? col_idx : wcol_q;
    row_ready = (state_q == StAccept);
    done      = (state_q == StFinish);
    nnz_count = nnz_q;
    overflow  = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mask_q  <= '0;
      row_q   <= '0;
      nnz_q   <= '0;
      ovf_q   <= 1'b0;
      addr_q  <= '0;
      wrow_q  <= '0;
      wcol_q  <= '0;
    end else begin
      // Address/index outputs hold their last written values between writes.
      if (wr_en) begin
        addr_q <= wr_addr;
        wrow_q <= wr_row;
        wcol_q <= wr_col;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            nnz_q   <= '0;
            ovf_q   <= 1'b0;
            row_q   <= '0;
            state_q <= StAccept;
          end
        end
        StAccept: begin
          if (row_valid) begin
            mask_q <= row_bits;
            if (row_bits != '0) begin
              state_q <= StScan;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= last_row ? StFinish : StAccept;
            end
          end
        end
        StScan: begin
          if (full) begin
            // Memory full: drop the rest of this row in a single cycle.
            ovf_q  <= 1'b1;
            mask_q <= '0;
          end else begin
            nnz_q  <= nnz_q + 1'b1;
            mask_q <= mask_clr;
          end
          if (full || mask_clr == '0) begin
            row_q   <= row_q + 1'b1;
            state_q <= last_row ? StFinish : StAccept;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_coo_encoder.sv
// Directed bench for coo_encoder: per-scenario tasks with inline checks against
// hand-computed COO write sequences.
module tb_coo_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       row_valid;
  logic       row_ready;
  logic [5:0] row_bits;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [3:0] nnz_count;
  logic       overflow;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Write log captured mid-cycle.
  logic [2:0] q_addr[$];
  logic [2:0] q_row[$];
  logic [2:0] q_col[$];
  int         q_cyc[$];
  int         done_cnt = 0;
  int         done_cyc = -1;
  int         hs_cyc   = -1;

  coo_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_bits  (row_bits),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .nnz_count (nnz_count),
    .overflow  (overflow),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      q_addr.push_back(wr_addr);
      q_row.push_back(wr_row);
      q_col.push_back(wr_col);
      q_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic clear_log();
    q_addr.delete();
    q_row.delete();
    q_col.delete();
    q_cyc.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_row(input logic [5:0] bits);
    bit hs = 1'b0;
    row_valid = 1'b1;
    row_bits  = bits;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = row_ready;
      if (hs) hs_cyc = cyc;
      @(posedge clk); #1;
    end
    row_valid = 1'b0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL handshake_timeout: row_ready %0b, required 1 within 50 cycles", row_ready);
    end
  endtask

  task automatic wait_done(input int base);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (done_cnt != base);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: done count %0d, required %0d", done_cnt, base + 1);
    end
  endtask

  task automatic run_encode(input logic [35:0] rows);
    int base = done_cnt;
    clear_log();
    do_start();
    for (int i = 0; i < 6; i++) send_row(rows[6*i +: 6]);
    wait_done(base);
  endtask

  task automatic check_identity(input string tag);
    checks++;
    if (q_addr.size() !== 6) begin
      errors++;
      $display("FAIL %s_count: writes %0d, required 6", tag, q_addr.size());
    end
    for (int i = 0; i < q_addr.size(); i++) begin
      checks++;
      if ({q_addr[i], q_row[i], q_col[i]} !== {3'(i), 3'(i), 3'(i)}) begin
        errors++;
        $display("FAIL %s_write%0d: addr/row/col %0d/%0d/%0d, required %0d/%0d/%0d",
                 tag, i, q_addr[i], q_row[i], q_col[i], i, i, i);
      end
    end
    checks++;
    if (nnz_count !== 4'd6 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: nnz %0d ovf %0b, required 6 0", tag, nnz_count, overflow);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; row_valid = 1'b0; row_bits = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({row_ready, wr_en, wr_addr, wr_row, wr_col, nnz_count, overflow, done} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: %b, required all zero",
               {row_ready, wr_en, wr_addr, wr_row, wr_col, nnz_count, overflow, done});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    int base = done_cnt;
    run_encode({6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001});
    check_identity("identity");
    checks++;
    if (done_cnt - base !== 1 || q_cyc.size() == 0 || done_cyc !== q_cyc[q_cyc.size()-1] + 1) begin
      errors++;
      $display("FAIL identity_done: pulses %0d at cycle %0d, required 1 right after last write",
               done_cnt - base, done_cyc);
    end
    @(negedge clk);
    checks++;
    if ({wr_en, wr_addr, wr_row, wr_col} !== {1'b0, 3'd5, 3'd5, 3'd5}) begin
      errors++;
      $display("FAIL identity_hold: en/addr/row/col %0b/%0d/%0d/%0d, required 0/5/5/5",
               wr_en, wr_addr, wr_row, wr_col);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int base = done_cnt;
    run_encode(36'd0);
    checks++;
    if (q_addr.size() !== 0 || nnz_count !== 4'd0) begin
      errors++;
      $display("FAIL zero_writes: writes %0d nnz %0d, required 0 0", q_addr.size(), nnz_count);
    end
    checks++;
    if (done_cnt - base !== 1 || done_cyc !== hs_cyc + 1) begin
      errors++;
      $display("FAIL zero_done: pulses %0d cycle %0d, required 1 at %0d",
               done_cnt - base, done_cyc, hs_cyc + 1);
    end
  endtask

  task automatic test_multibit();
    logic [2:0] exp_col[3];
    exp_col[0] = 3'd0; exp_col[1] = 3'd2; exp_col[2] = 3'd5;
    run_encode({30'd0, 6'b100101});
    checks++;
    if (q_addr.size() !== 3 || nnz_count !== 4'd3) begin
      errors++;
      $display("FAIL multibit_count: writes %0d nnz %0d, required 3 3", q_addr.size(), nnz_count);
    end
    for (int i = 0; i < q_addr.size() && i < 3; i++) begin
      checks++;
      if ({q_addr[i], q_row[i], q_col[i]} !== {3'(i), 3'd0, exp_col[i]}) begin
        errors++;
        $display("FAIL multibit_write%0d: addr/row/col %0d/%0d/%0d, required %0d/0/%0d",
                 i, q_addr[i], q_row[i], q_col[i], i, exp_col[i]);
      end
    end
    checks++;
    if (q_cyc.size() !== 3 || q_cyc[2] - q_cyc[0] !== 2) begin
      errors++;
      $display("FAIL multibit_consecutive: %0d writes not in 3 back-to-back cycles", q_cyc.size());
    end
  endtask

  task automatic test_overflow();
    int base = done_cnt;
    run_encode({24'd0, 6'b000011, 6'b111111});
    checks++;
    if (q_addr.size() !== 6) begin
      errors++;
      $display("FAIL overflow_count: writes %0d, required 6", q_addr.size());
    end
    for (int i = 0; i < q_addr.size(); i++) begin
      checks++;
      if ({q_addr[i], q_row[i], q_col[i]} !== {3'(i), 3'd0, 3'(i)}) begin
        errors++;
        $display("FAIL overflow_write%0d: addr/row/col %0d/%0d/%0d, required %0d/0/%0d",
                 i, q_addr[i], q_row[i], q_col[i], i, i);
      end
    end
    checks++;
    if (overflow !== 1'b1 || nnz_count !== 4'd6 || done_cnt - base !== 1) begin
      errors++;
      $display("FAIL overflow_status: ovf %0b nnz %0d done %0d, required 1 6 1",
               overflow, nnz_count, done_cnt - base);
    end
    do_start();
    checks++;
    if (overflow !== 1'b0 || nnz_count !== 4'd0) begin
      errors++;
      $display("FAIL overflow_clear: ovf %0b nnz %0d, required 0 0", overflow, nnz_count);
    end
    base = done_cnt;
    for (int i = 0; i < 6; i++) send_row(6'd0);
    wait_done(base);
  endtask

  task automatic test_back_to_back();
    int base = done_cnt;
    clear_log();
    do_start();
    for (int i = 0; i < 6; i++) begin
      send_row(6'(1 << i));
      // Encoder is in SCAN here; this start must be ignored.
      if (i == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
    end
    wait_done(base);
    check_identity("backpressure");
    checks++;
    if (done_cnt - base !== 1) begin
      errors++;
      $display("FAIL backpressure_done: pulses %0d, required 1", done_cnt - base);
    end
  endtask

  task automatic test_reset_mid_scan();
    int base;
    clear_log();
    do_start();
    send_row(6'b111111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    base = done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({row_ready, wr_en, wr_addr, wr_row, wr_col, nnz_count, overflow, done} !== 16'd0) begin
      errors++;
      $display("FAIL midreset_outputs: %b, required all zero",
               {row_ready, wr_en, wr_addr, wr_row, wr_col, nnz_count, overflow, done});
    end
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (done_cnt !== base || row_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: done pulses %0d row_ready %0b, required 0 0",
               done_cnt - base, row_ready);
    end
    run_encode({6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001});
    check_identity("after_reset");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_zero();
    test_multibit();
    test_overflow();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coo_encoder.md
Name: coo_encoder

Overview:
- Converts a dense binary adjacency matrix, streamed one row per handshake, into COO (row, col) entries.
- Emits one memory write per nonzero element, in row-major, ascending-column order.
- Drives the write port of the COO storage that the combination engine later reads by address.
- Sits between the host/adjacency loader and the COO memory; reports the nonzero count and overflow.

Parameters:
- MAT_ROWS, 6, number of matrix rows accepted per encode.
- MAT_COLS, 6, width of each row bitmask.
- COO_DEPTH, 6, number of COO entries the target memory holds.
- COO_BW, $clog2(COO_DEPTH), write address width.
- IDX_BW, $clog2(MAT_ROWS>MAT_COLS ? MAT_ROWS : MAT_COLS), row/col index width.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins an encode. Honoured only in IDLE.
- row_valid  input  1  row_bits is valid.
- row_ready  output  1  encoder can accept a row.
- row_bits  input  MAT_COLS  dense row mask; bit j set means edge (current row, j).
- wr_en  output  1  COO write strobe.
- wr_addr  output  COO_BW  COO entry address.
- wr_row  output  IDX_BW  row index of the entry.
- wr_col  output  IDX_BW  column index of the entry.
- nnz_count  output  COO_BW+1  entries written in the current/last encode.
- overflow  output  1  sticky; set when a nonzero is dropped because the memory is full.
- done  output  1  one-cycle pulse at the end of the encode.

Behaviour:
- Reset, any state: state=IDLE.
  - Outputs: row_ready=0, wr_en=0, wr_addr=0, wr_row=0, wr_col=0, nnz_count=0, overflow=0, done=0.
  - Clears the internal mask and the row counter.
  - Reset mid-encode abandons it; no done pulse is produced.
- States: IDLE, ACCEPT, SCAN, FINISH.
- IDLE:
  - row_ready=0.
  - On start=1: clear nnz_count, overflow and row counter, then go to ACCEPT.
- ACCEPT:
  - row_ready=1.
  - On row_valid&&row_ready at edge k: latch row_bits into the mask; row index = row counter.
  - If row_bits != 0, go to SCAN. The first wr_en is visible in cycle k+1.
  - If row_bits == 0: no writes. Increment the row counter. Go to FINISH if this was row MAT_ROWS-1, else stay in ACCEPT.
  - row_valid=0 holds the state indefinitely.
- SCAN (mask nonzero on entry):
  - row_ready=0.
  - Each cycle, a priority encoder selects the lowest set bit j of the mask.
  - wr_en, wr_addr, wr_row and wr_col are combinational from state and registers: wr_en=1, wr_addr=nnz_count[COO_BW-1:0], wr_row=row index, wr_col=j.
  - The memory captures the entry at the next edge. At that edge: clear bit j and increment nnz_count.
  - Throughput is one entry per cycle. A row with p nonzeros occupies exactly p SCAN cycles, plus one ACCEPT cycle per row handshake.
  - When the cleared mask becomes zero: increment the row counter, then go to FINISH if it was the last row, else ACCEPT.
- Full memory (nnz_count == COO_DEPTH while in SCAN):
  - wr_en=0 and overflow<=1.
  - Discard the remaining mask bits of this row; nnz_count saturates at COO_DEPTH.
  - Follow the same end-of-row transition as above.
  - Later rows are still accepted. Any nonzero in them sets overflow again and is dropped without a write.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Held until the next start: nnz_count and overflow.
- Outside SCAN:
  - wr_en=0.
  - wr_row, wr_col and wr_addr are don't-care but must not change unless wr_en=1; keep them at their last values.
- start while not in IDLE is ignored, including start coincident with the final handshake.
- Rows are always counted, overflow or not. Exactly MAT_ROWS handshakes per encode.

Test Plan:
- Identity: start, then rows 6'b000001, 6'b000010 … 6'b100000 with row_valid held.
  - Required: 6 writes at addr 0..5 with (row,col)=(i,i), one per row; done 1 cycle after the last write; nnz_count=6; overflow=0.
- Zero matrix: 6 rows of 0.
  - Required: no wr_en; done one cycle after the 6th handshake; nnz_count=0.
- Multi-bit row: row0=6'b100101, rows 1..5 zero.
  - Required: three consecutive wr_en cycles with (0,0)@0, (0,2)@1, (0,5)@2; nnz_count=3.
- Overflow: row0=6'b111111, row1=6'b000011, rest zero.
  - Required: 6 writes (0,0..5)@0..5, then no write for row1; overflow=1; nnz_count=6; done still pulses; overflow is cleared by the next start.
- Backpressure and ignored start:
  - Identity rows with row_valid low for 3 cycles between rows: same write sequence, no extra writes.
  - start pulsed during SCAN: no effect.
- Reset mid-SCAN: assert reset during row0=6'b111111 after 2 writes.
  - Required: the next cycle is IDLE with all outputs 0 and no done.
  - A fresh start with the identity matrix encodes correctly from addr 0.
